// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: steps one digit per scan_clk rising edge,
// snapshots data/dp/blank once per frame. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic        scan_q;
    logic        tick;
    logic        wrap;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [31:0] snap_data;
    logic [31:0] snap_data_next;
    logic [7:0]  snap_dp;
    logic [7:0]  snap_dp_next;
    logic [7:0]  snap_blank;
    logic [7:0]  snap_blank_next;
    logic        snap_valid;
    logic        snap_valid_next;
    logic [3:0]  nibble;
    logic        lz_dark;
    logic        dark;
    logic [7:0]  an_next;
    logic [6:0]  seg_next;
    logic        dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-cycle view of counter and snapshot, so outputs show the new digit right after a tick.
    always_comb begin
        tick            = scan_clk & ~scan_q;
        wrap            = tick && (idx == 3'd7);
        idx_next        = tick ? idx + 3'd1 : idx;
        snap_data_next  = wrap ? data       : snap_data;
        snap_dp_next    = wrap ? dp_in      : snap_dp;
        snap_blank_next = wrap ? blank_mask : snap_blank;
        snap_valid_next = snap_valid | wrap;
        nibble          = snap_data_next[{idx_next, 2'b00} +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [2:0] h_q;
    logic [2:0] h_next;

    // Highest digit that is nonzero or carries a decimal point; digit 0 is always shown.
    function automatic logic [2:0] calc_h(input logic [31:0] d, input logic [7:0] p);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ((d[4*k +: 4] != 4'h0) || p[k]) r = 3'(k);
        end
        return r;
    endfunction

    always_comb begin
        h_next  = wrap ? calc_h(data, dp_in) : h_q;
        lz_dark = (idx_next > h_next);
    end

    always_ff @(posedge clk) begin
        if (rst) h_q <= 3'd0;
        else     h_q <= h_next;
    end
`else
    always_comb lz_dark = 1'b0;
`endif

    // Nothing is lit until a frame has been snapshotted after reset.
    always_comb begin
        dark     = ~en | ~snap_valid_next | snap_blank_next[idx_next] | lz_dark;
        an_next  = dark ? 8'hFF : ~(8'b1 << idx_next);
        seg_next = dark ? 7'h7F : hex_to_seg(nibble);
        dp_next  = dark ? 1'b1  : ~snap_dp_next[idx_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q     <= 1'b0;
            idx        <= 3'd7;
            snap_data  <= 32'h0;
            snap_dp    <= 8'h0;
            snap_blank <= 8'h0;
            snap_valid <= 1'b0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            scan_q     <= scan_clk;
            idx        <= idx_next;
            snap_data  <= snap_data_next;
            snap_dp    <= snap_dp_next;
            snap_blank <= snap_blank_next;
            snap_valid <= snap_valid_next;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: vector table per scan tick plus hand sequences
// for held scan_clk, enable, leading zeros and mid-frame reset.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        scan_clk;
    logic        en;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  blank_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp_in;
        logic [7:0]  blank;
        logic        en;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[20];

    seg7_scan_driver dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic pulse();
        scan_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        scan_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input logic [7:0] a, input logic [6:0] s, input logic d);
        exp_q.push_back({a, s, d});
    endtask

    // scoreboard
    task automatic check_out(input string name);
        logic [15:0] e;
        logic [15:0] got;
        e   = exp_q.pop_front();
        got = {an, seg, dp};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                     name, an, seg, dp, e[15:8], e[7:1], e[0]);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hFE, 7'h00, 1'b0};
        vecs[1]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hFD, 7'h78, 1'b1};
        vecs[2]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hFB, 7'h02, 1'b0};
        vecs[3]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hF7, 7'h12, 1'b1};
        vecs[4]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hEF, 7'h19, 1'b1};
        vecs[5]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hDF, 7'h30, 1'b1};
        vecs[6]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'hBF, 7'h24, 1'b1};
        vecs[7]  = '{32'h12345678, 8'h05, 8'h00, 1'b1, 8'h7F, 7'h79, 1'b1};
        vecs[8]  = '{32'h12345678, 8'h00, 8'h00, 1'b1, 8'hFE, 7'h00, 1'b1};
        vecs[9]  = '{32'h12345678, 8'h00, 8'h00, 1'b1, 8'hFD, 7'h78, 1'b1};
        vecs[10] = '{32'h12345678, 8'h00, 8'h00, 1'b1, 8'hFB, 7'h02, 1'b1};
        vecs[11] = '{32'h12345678, 8'h00, 8'h00, 1'b1, 8'hF7, 7'h12, 1'b1};
        vecs[12] = '{32'hFFFFFFFF, 8'h00, 8'h00, 1'b1, 8'hEF, 7'h19, 1'b1};
        vecs[13] = '{32'hFFFFFFFF, 8'h00, 8'h00, 1'b1, 8'hDF, 7'h30, 1'b1};
        vecs[14] = '{32'hFFFFFFFF, 8'h00, 8'h00, 1'b1, 8'hBF, 7'h24, 1'b1};
        vecs[15] = '{32'hFFFFFFFF, 8'h00, 8'h00, 1'b1, 8'h7F, 7'h79, 1'b1};
        vecs[16] = '{32'hFFFFFFFF, 8'h00, 8'h02, 1'b1, 8'hFE, 7'h0E, 1'b1};
        vecs[17] = '{32'hFFFFFFFF, 8'h00, 8'h02, 1'b1, 8'hFF, 7'h7F, 1'b1};
        vecs[18] = '{32'hFFFFFFFF, 8'h00, 8'h02, 1'b0, 8'hFF, 7'h7F, 1'b1};
        vecs[19] = '{32'hFFFFFFFF, 8'h00, 8'h02, 1'b1, 8'hF7, 7'h0E, 1'b1};

        rst        = 1'b1;
        scan_clk   = 1'b0;
        en         = 1'b0;
        data       = 32'h0;
        dp_in      = 8'h0;
        blank_mask = 8'h0;
        repeat (3) @(negedge clk);
        expect_out(8'hFF, 7'h7F, 1'b1);
        check_out("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            expect_out(8'hFF, 7'h7F, 1'b1);
            check_out("idle_dark");
        end

        // vector table, one scan tick per record
        for (int i = 0; i < 20; i++) begin
            data       = vecs[i].data;
            dp_in      = vecs[i].dp_in;
            blank_mask = vecs[i].blank;
            en         = vecs[i].en;
            pulse();
            expect_out(vecs[i].an, vecs[i].seg, vecs[i].dp);
            check_out($sformatf("vec%0d", i));
        end

        // scan_clk held high: one advance only (idx 3 -> 4)
        scan_clk = 1'b1;
        @(negedge clk);
        expect_out(8'hEF, 7'h0E, 1'b1);
        check_out("hold_first");
        repeat (49) @(negedge clk);
        expect_out(8'hEF, 7'h0E, 1'b1);
        check_out("hold_end");
        scan_clk = 1'b0;
        repeat (2) @(negedge clk);

        // enable acts without a tick
        en = 1'b0;
        @(negedge clk);
        expect_out(8'hFF, 7'h7F, 1'b1);
        check_out("en_off");
        en = 1'b1;
        @(negedge clk);
        expect_out(8'hEF, 7'h0E, 1'b1);
        check_out("en_on");

        // advance to idx 7, then load 00000A05 on the wrap
        repeat (3) pulse();
        data       = 32'h00000A05;
        dp_in      = 8'h00;
        blank_mask = 8'h00;
        pulse();
        expect_out(8'hFE, 7'h12, 1'b1);
        check_out("lz_d0");
        pulse();
        expect_out(8'hFD, 7'h40, 1'b1);
        check_out("lz_d1");
        pulse();
        expect_out(8'hFB, 7'h08, 1'b1);
        check_out("lz_d2");
        for (int k = 3; k < 8; k++) begin
            pulse();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            expect_out(8'hFF, 7'h7F, 1'b1);
`else
            expect_out(~(8'b1 << k), 7'h40, 1'b1);
`endif
            check_out($sformatf("lz_d%0d", k));
        end

        // mid-frame reset at idx 5, with a scan edge arriving together with rst
        data = 32'h0000000B;
        repeat (6) pulse();
        rst      = 1'b1;
        scan_clk = 1'b1;
        @(negedge clk);
        expect_out(8'hFF, 7'h7F, 1'b1);
        check_out("rst_dark");
        @(negedge clk);
        expect_out(8'hFF, 7'h7F, 1'b1);
        check_out("rst_wins");
        scan_clk = 1'b0;
        rst      = 1'b0;
        data     = 32'h000000ED;
        repeat (2) @(negedge clk);
        pulse();
        expect_out(8'hFE, 7'h21, 1'b1);
        check_out("post_rst_d0");
        pulse();
        expect_out(8'hFD, 7'h06, 1'b1);
        check_out("post_rst_d1");

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
